// File: rtl/wb_rr_arbiter.sv
// Writeback scheduler: per-channel FIFOs drained round-robin into one DRAM write port.
// Define WB_STRICT_PRIO_EN to replace round-robin with fixed lowest-index priority.
module wb_rr_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16,
    parameter int LEN_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [LEN_W-1:0]         frame_len,
    input  logic                     clear_ovf,
    input  logic                     dram_ready,
    output logic                     dram_wen,
    output logic [DATA_W-1:0]        dram_data,
    output logic [ADDR_W-1:0]        dram_addr,
    output logic                     busy,
    output logic                     frame_done,
    output logic [NUM_CH-1:0]        ovf
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [NUM_CH-1:0] full, empty, push, pop, ovf_set;
    logic [NUM_CH-1:0] ovf_q;
    logic [DATA_W-1:0] head [NUM_CH];

    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic [ADDR_W-1:0] addr_p1;

    logic [ADDR_W-1:0] addr_cnt;
    logic [LEN_W-1:0]  issue_cnt, acc_cnt, len_q;
    logic              slot_free, accept, can_issue, gnt_found, grant;
    logic [CH_W-1:0]   gnt_idx, scan_idx;

    // Stage p0: per-channel FIFOs; a full FIFO still accepts when it is popped the same cycle
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_fifo
        logic [DATA_W-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0]  wr_ptr, rd_ptr;
        logic [CNT_W-1:0]  cnt;

        assign full[ch]    = (cnt == CNT_W'(FIFO_DEPTH));
        assign empty[ch]   = (cnt == '0);
        assign push[ch]    = ch_valid[ch] && (!full[ch] || pop[ch]);
        assign ovf_set[ch] = ch_valid[ch] && full[ch] && !pop[ch];
        assign head[ch]    = mem[rd_ptr];

        always_ff @(posedge clk) begin
            if (!reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push[ch]) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop[ch])  rd_ptr <= rd_ptr + PTR_W'(1);
                if (push[ch] && !pop[ch])
                    cnt <= cnt + CNT_W'(1);
                else if (pop[ch] && !push[ch])
                    cnt <= cnt - CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (push[ch]) mem[wr_ptr] <= ch_data[ch*DATA_W +: DATA_W];
        end
    end

    // Overflow set takes precedence over a simultaneous clear
    always_ff @(posedge clk) begin
        if (!reset) ovf_q <= '0;
        else        ovf_q <= (ovf_q & ~{NUM_CH{clear_ovf}}) | ovf_set;
    end

    assign slot_free = !vld_p1 || dram_ready;
    assign accept    = vld_p1 && dram_ready;
    assign can_issue = (state == S_RUN) && slot_free && (issue_cnt < len_q);
    assign grant     = can_issue && gnt_found;

`ifdef WB_STRICT_PRIO_EN
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan_idx = CH_W'(k);
            if (!gnt_found && !empty[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end
`else
    logic [CH_W-1:0] last_grant;

    // Scan starts just after the previous winner so every channel gets a turn
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan_idx = CH_W'((int'(last_grant) + 1 + k) % NUM_CH);
            if (!gnt_found && !empty[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)     last_grant <= CH_W'(NUM_CH - 1);
        else if (grant) last_grant <= gnt_idx;
    end
`endif

    always_comb begin
        pop = '0;
        if (grant) pop[gnt_idx] = 1'b1;
    end

    // Stage p1: output register, frozen while DRAM stalls a presented write
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            addr_p1 <= '0;
        end else if (grant) begin
            vld_p1  <= 1'b1;
            data_p1 <= head[gnt_idx];
            addr_p1 <= addr_cnt;
        end else if (slot_free) begin
            vld_p1  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_cnt  <= '0;
            issue_cnt <= '0;
            acc_cnt   <= '0;
            len_q     <= '0;
        end else if (state == S_IDLE && start) begin
            addr_cnt  <= base_addr;
            issue_cnt <= '0;
            acc_cnt   <= '0;
            len_q     <= frame_len;
        end else begin
            if (grant) begin
                addr_cnt  <= addr_cnt + ADDR_W'(1);
                issue_cnt <= issue_cnt + LEN_W'(1);
            end
            if (accept && state == S_RUN) acc_cnt <= acc_cnt + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = (frame_len == '0) ? S_DONE : S_RUN;
            S_RUN:   if (accept && (acc_cnt + LEN_W'(1) == len_q)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign dram_wen   = vld_p1;
    assign dram_data  = data_p1;
    assign dram_addr  = addr_p1;
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DONE);
    assign ovf        = ovf_q;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter: queue-based reference model plus directed and random traffic.
module tb_wb_rr_arbiter;
    localparam int NUM_CH = 4, DATA_W = 8, FIFO_DEPTH = 4, ADDR_W = 16, LEN_W = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [NUM_CH-1:0] ch_valid = '0;
    logic [NUM_CH*DATA_W-1:0] ch_data = '0;
    logic start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0] frame_len = '0;
    logic clear_ovf = 1'b0;
    logic dram_ready = 1'b0;
    logic dram_wen, busy, frame_done;
    logic [DATA_W-1:0] dram_data;
    logic [ADDR_W-1:0] dram_addr;
    logic [NUM_CH-1:0] ovf;

    wb_rr_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
                    .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data),
        .start(start), .base_addr(base_addr), .frame_len(frame_len),
        .clear_ovf(clear_ovf), .dram_ready(dram_ready), .dram_wen(dram_wen),
        .dram_data(dram_data), .dram_addr(dram_addr), .busy(busy),
        .frame_done(frame_done), .ovf(ovf));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t acc_log[$];
    logic [DATA_W-1:0] mq [NUM_CH][$];
    int m_state = 0;
    int m_last = NUM_CH - 1;
    int m_issued = 0, m_acc = 0, m_len = 0;
    logic [ADDR_W-1:0] m_base = '0;
    logic m_wen = 1'b0;
    logic [NUM_CH-1:0] m_ovf = '0;
    int checks = 0, failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock edge of the specified behaviour; states: 0 idle, 1 run, 2 done
    function automatic void model_step();
        bit acc, free, found;
        int nxt, c, cand;
        wr_t w;
        logic [NUM_CH-1:0] oset;
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) mq[i].delete();
            exp_q.delete();
            m_state = 0; m_last = NUM_CH - 1; m_wen = 1'b0; m_ovf = '0;
            m_issued = 0; m_acc = 0; m_len = 0;
            return;
        end
        acc  = m_wen && dram_ready;
        free = !m_wen || dram_ready;
        nxt  = m_state;
        case (m_state)
            0: if (start) begin
                m_base = base_addr; m_len = int'(frame_len); m_issued = 0; m_acc = 0;
                nxt = (frame_len == 0) ? 2 : 1;
            end
            1: if (acc) begin
                m_acc++;
                if (m_acc == m_len) nxt = 2;
            end
            default: nxt = 0;
        endcase
        found = 1'b0; c = 0;
        if (m_state == 1 && free && m_issued < m_len) begin
            for (int k = 0; k < NUM_CH; k++) begin
`ifdef WB_STRICT_PRIO_EN
                cand = k;
`else
                cand = (m_last + 1 + k) % NUM_CH;
`endif
                if (!found && mq[cand].size() > 0) begin
                    found = 1'b1;
                    c = cand;
                end
            end
        end
        if (found) begin
            w.addr = m_base + ADDR_W'(m_issued);
            w.data = mq[c].pop_front();
            exp_q.push_back(w);
            m_issued++; m_last = c; m_wen = 1'b1;
        end else if (free) begin
            m_wen = 1'b0;
        end
        oset = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_valid[i]) begin
                if (mq[i].size() < FIFO_DEPTH) mq[i].push_back(ch_data[i*DATA_W +: DATA_W]);
                else oset[i] = 1'b1;
            end
        end
        if (clear_ovf) m_ovf = '0;
        m_ovf |= oset;
        m_state = nxt;
    endfunction

    // Monitor: compares status every cycle and checks each presented write against the scoreboard
    always @(negedge clk) begin
        wr_t a;
        chk("wen", 32'(dram_wen), 32'(m_wen));
        chk("busy", 32'(busy), 32'(m_state != 0));
        chk("frame_done", 32'(frame_done), 32'(m_state == 2));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        if (dram_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_write actual addr=0x%0h data=0x%0h required none", dram_addr, dram_data);
            end else begin
                chk("wr_addr", 32'(dram_addr), 32'(exp_q[0].addr));
                chk("wr_data", 32'(dram_data), 32'(exp_q[0].data));
                if (dram_ready) begin
                    a.addr = dram_addr; a.data = dram_data;
                    acc_log.push_back(a);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wait_idle(string tag, int max);
        int n = 0;
        while (busy !== 1'b0 && n < max) begin
            cycle();
            n++;
        end
        if (busy !== 1'b0) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual busy=%b required 0", tag, busy);
        end
    endtask

    task automatic run_frame(logic [ADDR_W-1:0] base, logic [LEN_W-1:0] len);
        acc_log.delete();
        base_addr = base; frame_len = len; start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; ch_valid = '1; ch_data = '1; start = 1'b1; base_addr = 16'h1234;
        frame_len = 16'd5; clear_ovf = 1'b1; dram_ready = 1'b1;
        repeat (2) cycle();
        chk("rst_wen", 32'(dram_wen), 0);
        chk("rst_data", 32'(dram_data), 0);
        chk("rst_addr", 32'(dram_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_ovf", 32'(ovf), 0);
        reset = 1'b1; ch_valid = '0; start = 1'b0; clear_ovf = 1'b0;
        repeat (4) cycle();
        chk("idle_no_wen", 32'(dram_wen), 0);

        // Basic frame, one entry per channel
        ch_data = {8'h44, 8'h33, 8'h22, 8'h11}; ch_valid = 4'b1111;
        cycle();
        ch_valid = '0;
        run_frame(16'h0100, 16'd4);
        wait_idle("t_basic", 50);
        chk("basic_count", acc_log.size(), 4);
        for (int j = 0; j < 4 && j < acc_log.size(); j++) begin
            chk("basic_addr", 32'(acc_log[j].addr), 32'h0100 + j);
            chk("basic_data", 32'(acc_log[j].data), 32'h11 * (j + 1));
        end

        // Two active channels, three entries each
        for (int j = 0; j < 3; j++) begin
            ch_data = '0;
            ch_data[15:8]  = 8'(8'hA0 + j);
            ch_data[31:24] = 8'(8'hB0 + j);
            ch_valid = 4'b1010;
            cycle();
        end
        ch_valid = '0;
        run_frame(16'h0200, 16'd6);
        wait_idle("t_rr", 50);
        chk("rr_count", acc_log.size(), 6);
        for (int j = 0; j < 6 && j < acc_log.size(); j++) begin
            chk("rr_addr", 32'(acc_log[j].addr), 32'h0200 + j);
`ifdef WB_STRICT_PRIO_EN
            chk("rr_data", 32'(acc_log[j].data), (j < 3) ? 32'hA0 + j : 32'hB0 + j - 3);
`else
            chk("rr_data", 32'(acc_log[j].data), ((j % 2) == 0) ? 32'hA0 + j / 2 : 32'hB0 + j / 2);
`endif
        end

        // Backpressure for three cycles on a presented write
        ch_data = {8'h64, 8'h63, 8'h62, 8'h61}; ch_valid = 4'b1111;
        cycle();
        ch_data = {8'h00, 8'h00, 8'h66, 8'h65}; ch_valid = 4'b0011;
        cycle();
        ch_valid = '0;
        run_frame(16'h0300, 16'd6);
        cycle();
        dram_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            cycle();
            chk("stall_wen", 32'(dram_wen), 1);
        end
        dram_ready = 1'b1;
        wait_idle("t_stall", 50);
        chk("stall_count", acc_log.size(), 6);
        for (int j = 0; j < 6 && j < acc_log.size(); j++)
            chk("stall_addr", 32'(acc_log[j].addr), 32'h0300 + j);

        // Overflow on channel 2 while idle
        for (int j = 0; j < FIFO_DEPTH + 2; j++) begin
            ch_data = '0; ch_data[23:16] = 8'(8'h50 + j); ch_valid = 4'b0100;
            cycle();
        end
        ch_valid = '0;
        chk("ovf_set", 32'(ovf), 32'b0100);
        clear_ovf = 1'b1;
        cycle();
        chk("ovf_clear", 32'(ovf), 0);
        ch_data[23:16] = 8'h5F; ch_valid = 4'b0100;
        cycle();
        chk("ovf_set_wins", 32'(ovf), 32'b0100);
        ch_valid = '0;
        cycle();
        clear_ovf = 1'b0;
        chk("ovf_clear2", 32'(ovf), 0);
        run_frame(16'h0400, 16'd4);
        wait_idle("t_ovf", 50);
        chk("ovf_count", acc_log.size(), 4);
        for (int j = 0; j < 4 && j < acc_log.size(); j++)
            chk("ovf_data", 32'(acc_log[j].data), 32'h50 + j);

        // Zero-length frame
        run_frame(16'h0500, 16'd0);
        chk("len0_done", 32'(frame_done), 1);
        chk("len0_busy", 32'(busy), 1);
        cycle();
        chk("len0_done_off", 32'(frame_done), 0);
        chk("len0_busy_off", 32'(busy), 0);

        // Start during RUN is ignored
        for (int j = 0; j < 3; j++) begin
            ch_data = '0; ch_data[7:0] = 8'(8'h70 + j); ch_valid = 4'b0001;
            cycle();
        end
        ch_valid = '0;
        run_frame(16'h0600, 16'd3);
        base_addr = 16'h0900; frame_len = 16'd9; start = 1'b1;
        cycle();
        start = 1'b0;
        wait_idle("t_restart", 50);
        chk("restart_count", acc_log.size(), 3);
        for (int j = 0; j < 3 && j < acc_log.size(); j++) begin
            chk("restart_addr", 32'(acc_log[j].addr), 32'h0600 + j);
            chk("restart_data", 32'(acc_log[j].data), 32'h70 + j);
        end

        // Address counter wraps at the top of the address space
        for (int j = 0; j < 3; j++) begin
            ch_data = '0; ch_data[15:8] = 8'(8'h80 + j); ch_valid = 4'b0010;
            cycle();
        end
        ch_valid = '0;
        run_frame(16'hFFFE, 16'd3);
        wait_idle("t_wrap", 50);
        chk("wrap_count", acc_log.size(), 3);
        for (int j = 0; j < 3 && j < acc_log.size(); j++)
            chk("wrap_addr", 32'(acc_log[j].addr), (32'hFFFE + j) & 32'hFFFF);

        // Random traffic with one mid-run reset
        for (int n = 0; n < 3000; n++) begin
            ch_valid   = NUM_CH'($urandom & $urandom);
            ch_data    = $urandom;
            dram_ready = ($urandom_range(0, 3) != 0);
            start      = ($urandom_range(0, 15) == 0);
            base_addr  = ($urandom_range(0, 7) == 0) ? 16'hFFFC : 16'($urandom);
            frame_len  = 16'($urandom_range(0, 10));
            clear_ovf  = ($urandom_range(0, 29) == 0);
            reset      = (n != 1500);
            cycle();
        end
        reset = 1'b1; ch_valid = '0; start = 1'b0; clear_ovf = 1'b0; dram_ready = 1'b1;
        repeat (20) cycle();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
